// File: rtl/adv7280a_mode_ctrl.sv
// Timing-mode controller for the ADV7280A frontend: measures HS period and frame
// line count, classifies NTSC/PAL with lock hysteresis, and drives the hv_in_config words.
module adv7280a_mode_ctrl #(
  parameter int unsigned STABLE_FRAMES = 4,
  parameter int unsigned MISS_FRAMES   = 3,
  parameter int unsigned TIMEOUT_LINES = 1024,
  parameter int unsigned HP_MIN        = 1600,
  parameter int unsigned HP_MAX        = 1850,
  parameter int unsigned HP_SPLIT      = 1722
) (
  input  logic        PCLK_i,
  input  logic        reset_n,
  input  logic        HS_i,
  input  logic        frame_change_i,
  input  logic [10:0] vtotal_i,
  input  logic        interlace_i,
  input  logic [1:0]  mode_force_i,
  output logic [31:0] hv_in_config,
  output logic [31:0] hv_in_config2,
  output logic [31:0] hv_in_config3,
  output logic        mode_pal_o,
  output logic        locked_o,
  output logic        mode_change_o
);

  localparam int unsigned HW = 12;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 16;
  localparam logic [HW-1:0] HCNT_MAX = '1;

  localparam logic [31:0] NTSC_CFG1 = {8'd62, 12'd720, 12'd858};
  localparam logic [31:0] NTSC_CFG2 = {2'b0, 9'd15, 12'b0, 9'd57};
  localparam logic [31:0] NTSC_CFG3 = {4'b0, 12'd0, 4'd3, 12'd240};
  localparam logic [31:0] PAL_CFG1  = {8'd63, 12'd720, 12'd864};
  localparam logic [31:0] PAL_CFG2  = {2'b0, 9'd19, 12'b0, 9'd69};
  localparam logic [31:0] PAL_CFG3  = {4'b0, 12'd0, 4'd3, 12'd288};

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  state_e        state_q;
  logic          hs_q;
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hper_q;
  logic [LW-1:0] line_q;
  logic          cand_q;
  logic [CW-1:0] stable_q;
  logic [CW-1:0] miss_q;
  logic          enter_q;
  logic          pal_q;
  logic          mc_q;
  logic          locked_q;
  logic [31:0]   cfg1_q, cfg2_q, cfg3_q;

  logic          hs_rise;
  logic          hp_valid;
  logic          cls_pal;
  logic [10:0]   vt_lo, vt_hi;
  logic          frame_ok;
  logic          timeout;
  logic          pal_d;

  // Frame classification, line timeout and the next config selection.
  always_comb begin
    hs_rise  = HS_i & ~hs_q;
    hp_valid = (32'(hper_q) >= HP_MIN) && (32'(hper_q) <= HP_MAX);
    cls_pal  = 32'(hper_q) >= HP_SPLIT;
    vt_lo    = 11'd260;
    vt_hi    = 11'd264;
    case ({cls_pal, interlace_i})
      2'b01:   begin vt_lo = 11'd520; vt_hi = 11'd530; end
      2'b10:   begin vt_lo = 11'd310; vt_hi = 11'd314; end
      2'b11:   begin vt_lo = 11'd620; vt_hi = 11'd630; end
      default: begin vt_lo = 11'd260; vt_hi = 11'd264; end
    endcase
    frame_ok = hp_valid && (vtotal_i >= vt_lo) && (vtotal_i <= vt_hi);
    timeout  = hs_rise && ((32'(line_q) + 32'd1) >= TIMEOUT_LINES);
    pal_d    = pal_q;
    if (mode_force_i == 2'b01)      pal_d = 1'b0;
    else if (mode_force_i == 2'b10) pal_d = 1'b1;
    else if (enter_q)               pal_d = cand_q;
  end

  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_UNLOCKED;
      hs_q     <= 1'b0;
      hcnt_q   <= '0;
      hper_q   <= '0;
      line_q   <= '0;
      cand_q   <= 1'b0;
      stable_q <= '0;
      miss_q   <= '0;
      enter_q  <= 1'b0;
      pal_q    <= 1'b0;
      mc_q     <= 1'b0;
      locked_q <= 1'b0;
      cfg1_q   <= NTSC_CFG1;
      cfg2_q   <= NTSC_CFG2;
      cfg3_q   <= NTSC_CFG3;
    end else begin
      hs_q    <= HS_i;
      enter_q <= 1'b0;
      if (hs_rise) begin
        hper_q <= hcnt_q;
        hcnt_q <= HW'(1);
      end else if (hcnt_q != HCNT_MAX) begin
        hcnt_q <= hcnt_q + HW'(1);
      end

      // Timeout wins over any frame event in the same cycle.
      if (timeout) begin
        state_q  <= ST_UNLOCKED;
        line_q   <= '0;
        stable_q <= '0;
        miss_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        if (frame_change_i) line_q <= '0;
        else if (hs_rise)   line_q <= line_q + LW'(1);

        if (frame_change_i) begin
          case (state_q)
            ST_UNLOCKED: begin
              if (frame_ok) begin
                cand_q   <= cls_pal;
                stable_q <= CW'(1);
                if (STABLE_FRAMES <= 1) begin
                  state_q  <= ST_LOCKED;
                  miss_q   <= '0;
                  enter_q  <= 1'b1;
                  locked_q <= 1'b1;
                end else begin
                  state_q <= ST_CANDIDATE;
                end
              end
            end
            ST_CANDIDATE: begin
              if (!frame_ok) begin
                state_q  <= ST_UNLOCKED;
                stable_q <= '0;
              end else if (cls_pal == cand_q) begin
                stable_q <= stable_q + CW'(1);
                if ((32'(stable_q) + 32'd1) >= STABLE_FRAMES) begin
                  state_q  <= ST_LOCKED;
                  miss_q   <= '0;
                  enter_q  <= 1'b1;
                  locked_q <= 1'b1;
                end
              end else begin
                cand_q   <= cls_pal;
                stable_q <= CW'(1);
              end
            end
            ST_LOCKED: begin
              if (frame_ok && (cls_pal == cand_q)) begin
                miss_q <= '0;
              end else if ((32'(miss_q) + 32'd1) >= MISS_FRAMES) begin
                state_q  <= ST_UNLOCKED;
                miss_q   <= '0;
                stable_q <= '0;
                locked_q <= 1'b0;
              end else begin
                miss_q <= miss_q + CW'(1);
              end
            end
            default: begin
              state_q  <= ST_UNLOCKED;
              locked_q <= 1'b0;
            end
          endcase
        end
      end

      // Config words only move together with the mode_change pulse.
      mc_q   <= pal_d != pal_q;
      pal_q  <= pal_d;
      cfg1_q <= pal_d ? PAL_CFG1 : NTSC_CFG1;
      cfg2_q <= pal_d ? PAL_CFG2 : NTSC_CFG2;
      cfg3_q <= pal_d ? PAL_CFG3 : NTSC_CFG3;
    end
  end

  assign hv_in_config  = cfg1_q;
  assign hv_in_config2 = cfg2_q;
  assign hv_in_config3 = cfg3_q;
  assign mode_pal_o    = pal_q;
  assign locked_o      = locked_q;
  assign mode_change_o = mc_q;

endmodule

// File: tb/tb_adv7280a_mode_ctrl.sv
// Bench for adv7280a_mode_ctrl: directed scenarios plus random frames, checked every
// cycle against a timestamp/rule-based reference model.
module tb_adv7280a_mode_ctrl;

  localparam int STABLE = 4;
  localparam int MISS   = 3;
  localparam int TMO    = 1024;
  localparam int HPMIN  = 1600;
  localparam int HPMAX  = 1850;
  localparam int HPSPL  = 1722;

  localparam logic [31:0] N1 = 32'h3E2D035A;
  localparam logic [31:0] N2 = 32'h01E00039;
  localparam logic [31:0] N3 = 32'h000030F0;
  localparam logic [31:0] P1 = 32'h3F2D0360;
  localparam logic [31:0] P2 = 32'h02600045;
  localparam logic [31:0] P3 = 32'h00003120;

  logic        PCLK_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        HS_i = 1'b0;
  logic        frame_change_i = 1'b0;
  logic [10:0] vtotal_i = '0;
  logic        interlace_i = 1'b0;
  logic [1:0]  mode_force_i = 2'b00;
  logic [31:0] hv_in_config, hv_in_config2, hv_in_config3;
  logic        mode_pal_o, locked_o, mode_change_o;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  adv7280a_mode_ctrl #(
    .STABLE_FRAMES(STABLE), .MISS_FRAMES(MISS), .TIMEOUT_LINES(TMO),
    .HP_MIN(HPMIN), .HP_MAX(HPMAX), .HP_SPLIT(HPSPL)
  ) dut (
    .PCLK_i(PCLK_i), .reset_n(reset_n), .HS_i(HS_i), .frame_change_i(frame_change_i),
    .vtotal_i(vtotal_i), .interlace_i(interlace_i), .mode_force_i(mode_force_i),
    .hv_in_config(hv_in_config), .hv_in_config2(hv_in_config2), .hv_in_config3(hv_in_config3),
    .mode_pal_o(mode_pal_o), .locked_o(locked_o), .mode_change_o(mode_change_o)
  );

  always #5 PCLK_i = ~PCLK_i;

  // Reference model: HS period from edge timestamps, class from range arithmetic.
  int m_cyc, m_last_rise, m_hper, m_lines, m_state, m_stable, m_miss;
  bit m_prev_hs, m_cand, m_load, m_pal, m_mc, m_locked;

  function automatic int classify(input int hp, input int vt, input bit il);
    int c, lo, hi;
    if (hp < HPMIN || hp > HPMAX) return -1;
    c  = (hp < HPSPL) ? 0 : 1;
    lo = (c == 1 ? 310 : 260) * (il ? 2 : 1);
    hi = lo + (il ? 10 : 4);
    return (vt >= lo && vt <= hi) ? c : -1;
  endfunction

  always @(posedge PCLK_i or negedge reset_n) begin
    int  cls;
    bit  rise, load_now, want;
    if (!reset_n) begin
      m_cyc = 0; m_last_rise = 1; m_hper = 0; m_lines = 0; m_state = 0;
      m_stable = 0; m_miss = 0; m_prev_hs = 0; m_cand = 0; m_load = 0;
      m_pal = 0; m_mc = 0; m_locked = 0;
    end else begin
      m_cyc++;
      rise = HS_i && !m_prev_hs;
      m_prev_hs = HS_i;
      cls = classify(m_hper, int'(vtotal_i), interlace_i);
      if (rise) begin
        m_hper = (m_cyc - m_last_rise > 4095) ? 4095 : m_cyc - m_last_rise;
        m_last_rise = m_cyc;
      end
      load_now = m_load;
      m_load = 0;
      if (rise && m_lines + 1 >= TMO) begin
        m_state = 0; m_lines = 0; m_stable = 0; m_miss = 0;
      end else begin
        if (frame_change_i) m_lines = 0;
        else if (rise) m_lines++;
        if (frame_change_i) begin
          if (m_state == 0) begin
            if (cls >= 0) begin
              m_cand = cls[0]; m_stable = 1;
              if (STABLE <= 1) begin m_state = 2; m_miss = 0; m_load = 1; end
              else m_state = 1;
            end
          end else if (m_state == 1) begin
            if (cls < 0) begin m_state = 0; m_stable = 0; end
            else if (cls == int'(m_cand)) begin
              m_stable++;
              if (m_stable >= STABLE) begin m_state = 2; m_miss = 0; m_load = 1; end
            end else begin m_cand = cls[0]; m_stable = 1; end
          end else begin
            if (cls == int'(m_cand)) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss >= MISS) begin m_state = 0; m_miss = 0; m_stable = 0; end
            end
          end
        end
      end
      m_locked = (m_state == 2);
      want = m_pal;
      if (mode_force_i == 2'b01) want = 0;
      else if (mode_force_i == 2'b10) want = 1;
      else if (load_now) want = m_cand;
      m_mc = (want != m_pal);
      m_pal = want;
    end
  end

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge PCLK_i);
      check("cycle_outputs",
            128'({hv_in_config, hv_in_config2, hv_in_config3, mode_pal_o, locked_o, mode_change_o}),
            128'({m_pal ? P1 : N1, m_pal ? P2 : N2, m_pal ? P3 : N3, m_pal, m_locked, m_mc}));
      if (mode_change_o === 1'b1) pulses++;
    end
  endtask

  task automatic line(input int period, input bit fc, input int vt, input bit il);
    for (int c = 0; c < period; c++) begin
      HS_i = (c < 32);
      frame_change_i = fc && (c == 4);
      vtotal_i = 11'(vt);
      interlace_i = il;
      tick(1);
    end
    frame_change_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; HS_i = 1'b0; frame_change_i = 1'b0; mode_force_i = 2'b00;
    tick(3);
    reset_n = 1'b1;
    tick(2);
  endtask

  int per_tab[8] = '{1599, 1600, 1716, 1721, 1722, 1728, 1850, 1851};
  int vt_tab[10] = '{262, 263, 525, 531, 520, 312, 625, 630, 631, 700};

  initial begin
    int p0, p, v;
    bit il, fc;

    // Reset values
    tick(3);
    reset_n = 1'b1;
    check("reset_cfg", 128'({hv_in_config, hv_in_config2, hv_in_config3}), 128'({N1, N2, N3}));
    check("reset_flags", 128'({mode_pal_o, locked_o, mode_change_o}), 128'(3'b000));
    tick(2);

    // 1: NTSC lock, already NTSC so no pulse
    p0 = pulses;
    line(1716, 0, 525, 1);
    for (int i = 0; i < 4; i++) begin
      line(1716, 1, 525, 1);
      check($sformatf("ntsc_locked_f%0d", i + 1), 128'(locked_o), 128'(i == 3));
    end
    check("ntsc_model_locked", 128'(m_locked), 128'(1));
    check("ntsc_no_pulse", 128'(pulses - p0), 128'(0));
    check("ntsc_cfg", 128'({hv_in_config, mode_pal_o}), 128'({N1, 1'b0}));

    // 2: PAL lock from reset
    do_reset();
    p0 = pulses;
    line(1728, 0, 625, 1);
    for (int i = 0; i < 4; i++) line(1728, 1, 625, 1);
    check("pal_one_pulse", 128'(pulses - p0), 128'(1));
    check("pal_cfg1", 128'(hv_in_config), 128'(32'h3F2D0360));
    check("pal_vactive", 128'(hv_in_config3[11:0]), 128'(288));
    check("pal_mode", 128'({mode_pal_o, locked_o}), 128'(2'b11));
    check("pal_model_pal", 128'(m_pal), 128'(1));

    // 3: miss hysteresis
    p0 = pulses;
    line(1728, 1, 700, 1);
    line(1728, 1, 700, 1);
    line(1728, 1, 625, 1);
    check("miss2_still_locked", 128'(locked_o), 128'(1));
    check("miss2_no_pulse", 128'(pulses - p0), 128'(0));
    for (int i = 0; i < 3; i++) line(1728, 1, 700, 1);
    check("miss3_unlocked", 128'(locked_o), 128'(0));
    check("miss3_cfg_pal", 128'({hv_in_config, mode_pal_o}), 128'({P1, 1'b1}));

    // 4: line timeout, simultaneous frame_change ignored
    for (int i = 0; i < 4; i++) line(1728, 1, 625, 1);
    check("relock", 128'(locked_o), 128'(1));
    for (int k = 1; k <= TMO; k++) begin
      if (k == TMO) check("pre_timeout_locked", 128'(locked_o), 128'(1));
      HS_i = 1'b1; frame_change_i = (k == TMO); vtotal_i = 11'd625;
      tick(1);
      frame_change_i = 1'b0;
      tick(1);
      HS_i = 1'b0;
      tick(2);
    end
    check("timeout_unlocked", 128'(locked_o), 128'(0));
    check("timeout_model", 128'(m_locked), 128'(0));

    // 5: force mode over an auto PAL lock
    do_reset();
    line(1728, 0, 625, 1);
    for (int i = 0; i < 4; i++) line(1728, 1, 625, 1);
    tick(3);
    p0 = pulses;
    mode_force_i = 2'b01;
    tick(4);
    check("force_ntsc", 128'({hv_in_config, mode_pal_o, locked_o}), 128'({N1, 1'b0, 1'b1}));
    check("force_pulse", 128'(pulses - p0), 128'(1));
    mode_force_i = 2'b00;
    tick(4);
    check("auto_no_reload", 128'({mode_pal_o, hv_in_config2}), 128'({1'b0, N2}));
    check("auto_no_pulse", 128'(pulses - p0), 128'(1));
    mode_force_i = 2'b11;
    tick(3);
    check("mode11_auto", 128'(mode_pal_o), 128'(0));

    // 6: alternating classes never lock; async reset mid-candidate
    do_reset();
    mode_force_i = 2'b10;
    line(1716, 0, 525, 1);
    for (int i = 0; i < 6; i++) begin
      line((i % 2 == 0) ? 1728 : 1716, 1, (i % 2 == 0) ? 525 : 625, 1);
      check($sformatf("alt_unlocked_%0d", i), 128'(locked_o), 128'(0));
    end
    check("alt_forced_pal", 128'(mode_pal_o), 128'(1));
    tick(100);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_cfg", 128'({hv_in_config, hv_in_config2, hv_in_config3}), 128'({N1, N2, N3}));
    check("async_reset_flags", 128'({mode_pal_o, locked_o, mode_change_o}), 128'(3'b000));
    mode_force_i = 2'b00;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // 7: random frames, boundary periods and vtotals, occasional force changes
    line(1716, 0, 525, 1);
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        p = 1716; v = 525; il = 1'b1;
      end else begin
        p = per_tab[$urandom_range(0, 7)];
        v = vt_tab[$urandom_range(0, 9)];
        il = 1'($urandom_range(0, 1));
      end
      fc = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) mode_force_i = 2'($urandom_range(0, 3));
      line(p, fc, v, il);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule

// File: doc/adv7280a_mode_ctrl.md
Name: adv7280a_mode_ctrl

Overview:
Timing-mode controller for the ADV7280A composite/S-video frontend. It measures the HS period and frame line count, classifies the input as NTSC or PAL, and runs a lock/unlock state machine with hysteresis. On lock it programs the frontend's hv_in_config/hv_in_config2/hv_in_config3 words. It sits beside the frontend in the PCLK domain and feeds it directly.

Parameters:
STABLE_FRAMES, 4, consecutive same-class frames required to lock (1..15)
MISS_FRAMES, 3, consecutive mismatching/unknown frames required to drop lock (1..15)
TIMEOUT_LINES, 1024, HS edges without frame_change before forced unlock
HP_MIN, 1600, minimum valid HS period in PCLK cycles
HP_MAX, 1850, maximum valid HS period in PCLK cycles
HP_SPLIT, 1722, HS period < HP_SPLIT -> NTSC, otherwise PAL

Ports:
PCLK_i  in  1  pixel clock (2 clocks per pixel)
reset_n  in  1  asynchronous active-low reset
HS_i  in  1  raw HS from decoder; period is measured on rising edges
frame_change_i  in  1  one-cycle frame-start pulse from frontend
vtotal_i  in  11  lines per frame from frontend, valid when frame_change_i=1
interlace_i  in  1  interlace flag from frontend
mode_force_i  in  2  00 auto, 01 force NTSC, 10 force PAL, 11 treated as 00
hv_in_config  out  32  {H_SYNCLEN[7:0], H_ACTIVE[11:0], H_TOTAL[11:0]}
hv_in_config2  out  32  [29:21] V_BACKPORCH, [8:0] H_BACKPORCH, other bits 0
hv_in_config3  out  32  [27:16] V_SOF_LINE, [15:12] V_SYNCLEN, [11:0] V_ACTIVE, [31:28]=0
mode_pal_o  out  1  0 = NTSC config active, 1 = PAL config active
locked_o  out  1  detector locked
mode_change_o  out  1  one-cycle pulse on the cycle the config words change

Behaviour:
- Reset: state UNLOCKED; counters 0; mode_pal_o=0; locked_o=0; mode_change_o=0; config words hold NTSC values.
- NTSC set: H_TOTAL 858, H_ACTIVE 720, H_SYNCLEN 62, H_BACKPORCH 57, V_ACTIVE 240, V_SYNCLEN 3, V_BACKPORCH 15, V_SOF_LINE 0.
- PAL set: H_TOTAL 864, H_ACTIVE 720, H_SYNCLEN 63, H_BACKPORCH 69, V_ACTIVE 288, V_SYNCLEN 3, V_BACKPORCH 19, V_SOF_LINE 0.
- HS period: 12-bit counter, registered HS edge detect. On each rising edge, latch the counter into hper and restart the count at 1. The counter saturates at 4095. hper initialises to 0, which is invalid.
- Frame classification is sampled on frame_change_i, using hper and vtotal_i.
- A frame is valid when HP_MIN <= hper <= HP_MAX. It is then classified NTSC if hper < HP_SPLIT, else PAL.
- vtotal_i must be consistent with that class, else the frame is UNKNOWN:
  - NTSC: 520..530 when interlace_i=1, 260..264 when interlace_i=0.
  - PAL: 620..630 when interlace_i=1, 310..314 when interlace_i=0.
- States:
  - UNLOCKED: on a valid frame, record cand and set stable_cnt=1; go CANDIDATE (if STABLE_FRAMES=1, go straight to LOCKED).
  - CANDIDATE: a frame of class cand increments stable_cnt, and reaching STABLE_FRAMES goes LOCKED. A different valid class reloads cand with stable_cnt=1. UNKNOWN returns to UNLOCKED.
  - LOCKED: locked_o=1. A class==cand frame clears miss_cnt. UNKNOWN or a different class increments miss_cnt, and reaching MISS_FRAMES goes UNLOCKED.
  - Timeout: line_cnt counts HS rising edges and clears on frame_change_i. Reaching TIMEOUT_LINES forces UNLOCKED from any state and clears line_cnt. The timeout has priority over a same-cycle frame event.
- Config update (auto mode):
  - Entering LOCKED loads the config for cand one cycle after the transition. mode_change_o pulses in that same cycle, but only if the value differs from the current one.
  - Leaving LOCKED keeps the last config; there is no update while unlocked.
- Force mode:
  - Config follows mode_force_i one cycle after any change, with a mode_change_o pulse if the value differs.
  - The state machine keeps running and locked_o still reports detection.
  - Returning to auto does not reload the config until the next LOCKED entry.
- locked_o and mode_pal_o are registered. All config outputs change only in the same cycle as mode_change_o. reset_n asserted mid-frame returns everything to reset values immediately.

Test Plan:
1. NTSC stimulus: HS period 1716, interlace=1, vtotal=525, 4 frames -> locked_o=1 after the 4th frame_change; config stays NTSC; no mode_change_o pulse (already NTSC).
2. PAL stimulus: HS 1728, vtotal=625, interlace=1 -> after 4 frames, one mode_change_o pulse; hv_in_config=0x3F2D0360, hv_in_config3[11:0]=288, mode_pal_o=1.
3. Locked PAL with 2 UNKNOWN frames (vtotal=700) then a good one -> stays locked, no pulse; 3 consecutive UNKNOWN frames -> locked_o=0, config still PAL.
4. Locked, then HS continues but frame_change_i stops -> locked_o drops on the 1024th HS edge; simultaneous frame_change_i on that cycle is ignored.
5. Auto PAL locked, mode_force_i=01 -> next cycle NTSC config plus one pulse, locked_o stays 1; mode_force_i=00 -> config unchanged.
6. Alternate NTSC/PAL valid frames in CANDIDATE -> never locks; reset_n low mid-CANDIDATE -> all outputs return to reset values asynchronously.
